// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx_i with clk_i, samples each bit near its centre
// and presents every correctly framed byte on data_o with a one-cycle ready_o strobe.
module uart_rx #(
   parameter int CLK_FREQ     = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk_i,
   input  logic       nreset_i,
   input  logic       rx_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic [7:0] data_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : g_bad_cpb
         $error("uart_rx: CLKS_PER_BIT must be at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   logic          sync1_r;
   logic          sync2_r;
   logic          prev_r;
   state_t        state_r;
   state_t        state_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;
   logic [2:0]    idx_r;
   logic [2:0]    idx_s;
   logic [7:0]    shift_r;
   logic [7:0]    shift_s;
   logic [7:0]    data_r;
   logic [7:0]    data_s;
   logic          ready_r;
   logic          ready_s;
   logic          start_s;

   // A start needs a high-to-low transition, so a line stuck low never starts a frame.
   assign start_s = (sync2_r == 1'b0) && (prev_r == 1'b1) && valid_i;

   // Two-flop synchronizer plus the previous sample for falling-edge detection.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rx_i;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   // Receiver state, counters, shift register and registered outputs.
   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
         data_r  <= 8'h00;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shift_r <= shift_s;
         data_r  <= data_s;
         ready_r <= ready_s;
      end
   end

   // Next-state and datapath decode; every frame is timed from the falling start edge.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shift_s = shift_r;
      data_s  = data_r;
      ready_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (start_s) begin
               state_s = ST_START;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_START: begin
            if (cnt_r == HALF_CNT) begin
               cnt_s = CNT_ZERO;
               idx_s = 3'd0;
               if (sync2_r == 1'b0) begin
                  state_s = ST_DATA;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end

         ST_DATA: begin
            if (cnt_r == FULL_CNT) begin
               cnt_s          = CNT_ZERO;
               shift_s[idx_r] = sync2_r;
               if (idx_r == 3'd7) begin
                  state_s = ST_STOP;
                  idx_s   = 3'd0;
               end else begin
                  idx_s = idx_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end

         ST_STOP: begin
            if (cnt_r == FULL_CNT) begin
               // Leaving at mid stop bit lets a following start edge be caught with no gap.
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
               if (sync2_r == 1'b1) begin
                  data_s  = shift_r;
                  ready_s = 1'b1;
               end else begin
                  data_s  = data_r;
                  ready_s = 1'b0;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end

         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            idx_s   = 3'd0;
         end
      endcase
   end

   assign ready_o = ready_r;
   assign data_o  = data_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a short bit period (16 clocks) so frames stay brief.
module tb_uart_rx;

   localparam int CPB     = 16;
   localparam int LATENCY = 3 + CPB / 2 + 9 * CPB;

   logic       clk;
   logic       nreset;
   logic       rx;
   logic       valid;
   logic       ready;
   logic [7:0] data;

   int n_tests;
   int n_fail;
   int cyc;
   int pulses;
   int wide;
   int t_fall;
   int t_first;
   int base;
   logic       prev_ready;
   logic [7:0] cap_data [0:31];
   int         cap_cyc  [0:31];

   uart_rx #(
      .CLK_FREQ    (100_000_000),
      .BAUD        (9600),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk_i   (clk),
      .nreset_i(nreset),
      .rx_i    (rx),
      .valid_i (valid),
      .ready_o (ready),
      .data_o  (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: records every ready pulse, its byte and cycle stamp.
   always @(negedge clk) begin
      prev_ready <= ready;
      if (ready) begin
         if (pulses < 32) begin
            cap_data[pulses] <= data;
            cap_cyc[pulses]  <= cyc;
         end
         pulses <= pulses + 1;
         if (prev_ready) wide <= wide + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx     = 1'b0;
      t_fall = cyc;
      wait_clks(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(CPB);
      end
      rx = stop_bit;
      wait_clks(CPB);
      rx = 1'b1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      cyc        = 0;
      pulses     = 0;
      wide       = 0;
      prev_ready = 1'b0;
      nreset     = 1'b0;
      rx         = 1'b1;
      valid      = 1'b1;

      wait_clks(50);
      check_eq("reset_data", {24'd0, data}, 32'h00);
      check_eq("reset_ready", {31'd0, ready}, 32'd0);
      nreset = 1'b1;
      wait_clks(20);
      check_eq("idle_data", {24'd0, data}, 32'h00);
      check_eq("idle_pulses", pulses, 32'd0);

      // single frame 0x81
      send_byte(8'h81, 1'b1);
      wait_clks(4);
      check_eq("f81_pulses", pulses, 32'd1);
      check_eq("f81_data", {24'd0, cap_data[0]}, 32'h81);
      check_eq("f81_latency", cap_cyc[0] - t_fall, LATENCY);
      check_eq("f81_hold", {24'd0, data}, 32'h81);
      check_eq("f81_ready_low", {31'd0, ready}, 32'd0);

      // back-to-back 0x81, 0x80 with no idle gap
      wait_clks(20);
      base = pulses;
      send_byte(8'h81, 1'b1);
      t_first = t_fall;
      send_byte(8'h80, 1'b1);
      wait_clks(4);
      check_eq("b2b_pulses", pulses - base, 32'd2);
      check_eq("b2b_data0", {24'd0, cap_data[base]}, 32'h81);
      check_eq("b2b_data1", {24'd0, cap_data[base+1]}, 32'h80);
      check_eq("b2b_lat0", cap_cyc[base] - t_first, LATENCY);
      check_eq("b2b_spacing", cap_cyc[base+1] - cap_cyc[base], 10 * CPB);

      // valid dropped one bit into frame 0x00: frame still completes
      wait_clks(20);
      base = pulses;
      fork
         send_byte(8'h00, 1'b1);
         begin
            wait_clks(CPB);
            valid = 1'b0;
         end
      join
      wait_clks(4);
      check_eq("vdrop_pulses", pulses - base, 32'd1);
      check_eq("vdrop_data", {24'd0, data}, 32'h00);

      // valid low: 0x55 ignored
      wait_clks(20);
      base = pulses;
      send_byte(8'h55, 1'b1);
      wait_clks(20);
      check_eq("vlow_pulses", pulses - base, 32'd0);
      check_eq("vlow_data", {24'd0, data}, 32'h00);
      valid = 1'b1;
      wait_clks(20);

      // framing error on 0xA5, then line held low
      base = pulses;
      send_byte(8'hA5, 1'b0);
      rx = 1'b0;
      wait_clks(100);
      check_eq("ferr_pulses", pulses - base, 32'd0);
      check_eq("ferr_data", {24'd0, data}, 32'h00);
      rx = 1'b1;
      wait_clks(200);
      check_eq("stuck_low_pulses", pulses - base, 32'd0);
      send_byte(8'hC3, 1'b1);
      wait_clks(4);
      check_eq("after_low_pulses", pulses - base, 32'd1);
      check_eq("after_low_data", {24'd0, data}, 32'hC3);

      // short low glitch, then a normal frame with nominal latency
      wait_clks(20);
      base = pulses;
      rx = 1'b0;
      wait_clks(CPB / 4);
      rx = 1'b1;
      wait_clks(200);
      check_eq("glitch_pulses", pulses - base, 32'd0);
      check_eq("glitch_data", {24'd0, data}, 32'hC3);
      send_byte(8'h96, 1'b1);
      wait_clks(4);
      check_eq("post_glitch_pulses", pulses - base, 32'd1);
      check_eq("post_glitch_data", {24'd0, data}, 32'h96);
      check_eq("post_glitch_lat", cap_cyc[base] - t_fall, LATENCY);

      // reset in the middle of data bit 4 of 0xFF
      wait_clks(20);
      base = pulses;
      fork
         send_byte(8'hFF, 1'b1);
         begin
            wait_clks(CPB * 5 + CPB / 2);
            nreset = 1'b0;
            wait_clks(2);
            check_eq("midrst_data", {24'd0, data}, 32'h00);
            check_eq("midrst_ready", {31'd0, ready}, 32'd0);
            wait_clks(2);
            nreset = 1'b1;
         end
      join
      wait_clks(20);
      check_eq("midrst_pulses", pulses - base, 32'd0);
      check_eq("midrst_hold", {24'd0, data}, 32'h00);
      send_byte(8'h3C, 1'b1);
      wait_clks(4);
      check_eq("post_rst_pulses", pulses - base, 32'd1);
      check_eq("post_rst_data", {24'd0, data}, 32'h3C);

      check_eq("ready_width", wide, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
